// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one full-subtractor step per clock.
// Start/done handshake; the result and the final borrow hold until the next completion.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] res_next;
   logic [CNT_W-1:0] cnt;
   logic             bw;
   logic             d_bit;
   logic             bw_next;
   logic             accept;

   function automatic logic fs_diff(input logic x, input logic y, input logic bi);
      return x ^ y ^ bi;
   endfunction

   function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
      return (~x & y) | (~(x ^ y) & bi);
   endfunction

   assign accept  = start && (state != RUN);
   assign d_bit   = fs_diff(a_sh[0], b_sh[0], bw);
   assign bw_next = fs_borrow(a_sh[0], b_sh[0], bw);

   // New bit enters at the MSB end so that after WIDTH steps bit 0 sits at index 0.
   always_comb begin
      res_next = res >> 1;
      res_next[WIDTH-1] = d_bit;
   end

   // Control, borrow register and visible results
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         cnt        <= '0;
         bw         <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  state <= RUN;
                  busy  <= 1'b1;
                  bw    <= bin;
                  cnt   <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               bw  <= bw_next;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  diff       <= res_next;
                  borrow_out <= bw_next;
                  state      <= DONE;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  cnt        <= '0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // Operand and partial-result shift registers carry no reset; a partial result never reaches diff.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_sh <= a;
         b_sh <= b;
      end else if (state == RUN) begin
         a_sh <= a_sh >> 1;
         b_sh <= b_sh >> 1;
         res  <= res_next;
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random bench for serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8, bin8, busy8, done8, bo8;
   logic [7:0] a8, b8, diff8;
   logic       start1, bin1, busy1, done1, bo1;
   logic [0:0] a1, b1, diff1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
   );

   serial_subtractor #(.WIDTH(1)) u1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
      .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
      start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
      tick();
      tick();
      tests++;
      if ({busy8, done8, diff8, bo8} !== 11'd0) begin
         fails++;
         $display("FAIL reset_w8: got busy=%b done=%b diff=%h bo=%b, expected all zero", busy8, done8, diff8, bo8);
      end
      tests++;
      if ({busy1, done1, diff1, bo1} !== 4'd0) begin
         fails++;
         $display("FAIL reset_w1: got busy=%b done=%b diff=%b bo=%b, expected all zero", busy1, done1, diff1, bo1);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_w1_exhaustive();
      // index = {a,b,bin}; value = {borrow_out, diff}
      logic [1:0] exp_tab [8] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         a1 = v[2]; b1 = v[1]; bin1 = v[0]; start1 = 1'b1;
         tick();
         start1 = 1'b0; a1 = ~v[2]; b1 = ~v[1]; bin1 = ~v[0];
         tests++;
         if ({busy1, done1} !== 2'b10) begin
            fails++;
            $display("FAIL w1_run[%0d]: got busy=%b done=%b, expected busy=1 done=0", i, busy1, done1);
         end
         tick();
         tests++;
         if ({busy1, done1, bo1, diff1} !== {2'b01, exp_tab[i]}) begin
            fails++;
            $display("FAIL w1_done[%0d]: got busy=%b done=%b bo=%b diff=%b, expected busy=0 done=1 bo=%b diff=%b",
                     i, busy1, done1, bo1, diff1, exp_tab[i][1], exp_tab[i][0]);
         end
         tick();
      end
   endtask

   task automatic test_basic();
      logic [7:0] ta [4] = '{8'h05, 8'h03, 8'h00, 8'hFF};
      logic [7:0] tb [4] = '{8'h03, 8'h05, 8'h00, 8'hFF};
      logic       tc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [7:0] td [4] = '{8'h02, 8'hFE, 8'hFF, 8'h00};
      logic       te [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         a8 = ta[i]; b8 = tb[i]; bin8 = tc[i]; start8 = 1'b1;
         tick();
         start8 = 1'b0;
         for (int c = 1; c <= 8; c++) begin
            tests++;
            if ({busy8, done8} !== 2'b10) begin
               fails++;
               $display("FAIL basic[%0d]_cycle%0d: got busy=%b done=%b, expected busy=1 done=0", i, c, busy8, done8);
            end
            tick();
         end
         tests++;
         if ({busy8, done8, diff8, bo8} !== {2'b01, td[i], te[i]}) begin
            fails++;
            $display("FAIL basic[%0d]_done: got busy=%b done=%b diff=%h bo=%b, expected busy=0 done=1 diff=%h bo=%b",
                     i, busy8, done8, diff8, bo8, td[i], te[i]);
         end
         tick();
         tests++;
         if ({busy8, done8, diff8, bo8} !== {2'b00, td[i], te[i]}) begin
            fails++;
            $display("FAIL basic[%0d]_hold: got busy=%b done=%b diff=%h bo=%b, expected busy=0 done=0 diff=%h bo=%b",
                     i, busy8, done8, diff8, bo8, td[i], te[i]);
         end
      end
   endtask

   task automatic test_start_while_busy();
      int ndone = 0;
      a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0; a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         if (c == 4) begin
            a8 = 8'h00; b8 = 8'h01; start8 = 1'b1;
         end else if (c == 5) begin
            start8 = 1'b0; a8 = 8'h3C; b8 = 8'hC3;
         end
         if (done8) ndone++;
         tick();
      end
      start8 = 1'b0;
      tests++;
      if ({done8, diff8, bo8} !== {1'b1, 8'h0F, 1'b0}) begin
         fails++;
         $display("FAIL busy_start_done: got done=%b diff=%h bo=%b, expected done=1 diff=0f bo=0", done8, diff8, bo8);
      end
      tick();
      for (int c = 0; c < 10; c++) begin
         if (done8 || busy8) ndone++;
         tick();
      end
      tests++;
      if (ndone !== 0) begin
         fails++;
         $display("FAIL busy_start_extra: got %0d extra busy/done cycles, expected 0", ndone);
      end
   endtask

   task automatic test_back_to_back();
      a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int c = 1; c <= 8; c++) tick();
      tests++;
      if ({done8, diff8} !== {1'b1, 8'h02}) begin
         fails++;
         $display("FAIL b2b_first: got done=%b diff=%h, expected done=1 diff=02", done8, diff8);
      end
      a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0; a8 = 8'h00; b8 = 8'hFF;
      for (int c = 10; c <= 17; c++) begin
         tests++;
         if ({busy8, done8, diff8, bo8} !== {2'b10, 8'h02, 1'b0}) begin
            fails++;
            $display("FAIL b2b_hold_cycle%0d: got busy=%b done=%b diff=%h bo=%b, expected busy=1 done=0 diff=02 bo=0",
                     c, busy8, done8, diff8, bo8);
         end
         tick();
      end
      tests++;
      if ({done8, diff8, bo8} !== {1'b1, 8'h7F, 1'b0}) begin
         fails++;
         $display("FAIL b2b_second: got done=%b diff=%h bo=%b, expected done=1 diff=7f bo=0", done8, diff8, bo8);
      end
      tick();
   endtask

   task automatic test_reset_mid_run();
      int ndone = 0;
      a8 = 8'h01; b8 = 8'h02; bin8 = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int c = 1; c < 5; c++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++;
      if ({busy8, done8, diff8, bo8} !== 11'd0) begin
         fails++;
         $display("FAIL midrst_state: got busy=%b done=%b diff=%h bo=%b, expected all zero", busy8, done8, diff8, bo8);
      end
      for (int c = 0; c < 12; c++) begin
         if (done8 || busy8) ndone++;
         tick();
      end
      tests++;
      if (ndone !== 0 || diff8 !== 8'h00) begin
         fails++;
         $display("FAIL midrst_quiet: got %0d busy/done cycles diff=%h, expected 0 and diff=00", ndone, diff8);
      end
      a8 = 8'h20; b8 = 8'h10; bin8 = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int c = 1; c <= 8; c++) tick();
      tests++;
      if ({done8, diff8, bo8} !== {1'b1, 8'h10, 1'b0}) begin
         fails++;
         $display("FAIL midrst_after: got done=%b diff=%h bo=%b, expected done=1 diff=10 bo=0", done8, diff8, bo8);
      end
      tick();
   endtask

   task automatic test_random();
      for (int n = 0; n < 1000; n++) begin
         logic [7:0] ra, rb;
         logic       rc;
         logic [8:0] expv;
         int         waited;
         bit         got;
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         expv = {1'b0, ra} - {1'b0, rb} - {8'd0, rc};
         for (int g = $urandom_range(0, 3); g > 0; g--) tick();
         a8 = ra; b8 = rb; bin8 = rc; start8 = 1'b1;
         tick();
         start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
         got = 1'b0;
         waited = 0;
         while (!got && waited < 20) begin
            if (done8) got = 1'b1;
            else begin
               tick();
               waited++;
            end
         end
         tests++;
         if (!got || waited != 8 || {bo8, diff8} !== expv) begin
            fails++;
            $display("FAIL random[%0d] %h-%h-%b: got done=%b after %0d cycles bo=%b diff=%h, expected done after 8 bo=%b diff=%h",
                     n, ra, rb, rc, got, waited, bo8, diff8, expv[8], expv[7:0]);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_w1_exhaustive();
      test_basic();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
